modmul_seq: RTL and testbench

//  Sequencer directly upstream of the 16-bit ALU in the RSA datapath.
//  - Computes result = (a * b) mod n by MSB-first shift-and-add with conditional subtract.
//  - Issues every arithmetic step to the ALU through alu_ctrl/alu_in1/alu_in2 and consumes alu_res.
//  - Provides the modular-multiply primitive for the exponentiation controller.

---
 rtl/rsa_pkg.sv | 22 ++
 rtl/modmul_seq.sv | 178 +++++++++++++++++
 tb/tb_modmul_seq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath: ALU opcodes and the modular
// multiply sequencer state type.
package rsa_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  typedef enum logic [2:0] {
    IDLE,
    DBL,
    CMP1,
    SUB1,
    ADD,
    CMP2,
    SUB2,
    DONE
  } modmul_state_t;

endpackage

// File: rtl/modmul_seq.sv
// modmul_seq: sequencer computing (a*b) mod n by MSB-first shift-and-add with
// conditional subtraction, issuing every arithmetic step to an external
// registered ALU. Optional feature: define MODMUL_CYCLE_CNT_EN to add the
// cyc_cnt busy-cycle counter output.
module modmul_seq
  import rsa_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zero
`ifdef MODMUL_CYCLE_CNT_EN
  ,
  output logic [15:0]      cyc_cnt
`endif
);

  localparam int WT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
  localparam logic [WT_W-1:0] WT_MAX = WT_W'(ALU_LAT);
  localparam int IW = $clog2(WIDTH);

  modmul_state_t    state;
  logic [WT_W-1:0]  wt;
  logic [IW-1:0]    i;
  logic [WIDTH-1:0] a_r, b_r, n_r, acc, t;
  logic             chk_fail;
  logic             bad;
  logic             slt_true;
  logic             bit_set;
  logic [WIDTH-1:0] red_val;
  logic             unused_alu_zero;

  // The zero flag lags alu_res by a cycle, so decisions never look at it.
  assign unused_alu_zero = alu_zero;

  // A top bit set in n would let 2*acc wrap; n==0 has no residues at all.
  assign bad      = (n == '0) || n[WIDTH-1];
  assign slt_true = (alu_res == WIDTH'(1));
  assign bit_set  = b_r[i];

  // Value of t after a reduction step: fresh ALU result after a subtract, else t as is.
  always_comb begin
    red_val = t;
    if (state == SUB1 || state == SUB2) red_val = alu_res;
  end

  // Main sequencer: every op state holds ALU inputs for 1+ALU_LAT cycles and acts on the last edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wt       <= '0;
      i        <= '0;
      a_r      <= '0;
      b_r      <= '0;
      n_r      <= '0;
      acc      <= '0;
      t        <= '0;
      chk_fail <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      result   <= '0;
      alu_ctrl <= ALU_ADD;
      alu_in1  <= '0;
      alu_in2  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          alu_ctrl <= ALU_ADD;
          alu_in1  <= '0;
          alu_in2  <= '0;
          if (start) begin
            a_r      <= a;
            b_r      <= b;
            n_r      <= n;
            acc      <= '0;
            t        <= '0;
            i        <= IW'(WIDTH - 1);
            wt       <= '0;
            busy     <= 1'b1;
            chk_fail <= bad;
            state    <= bad ? DONE : DBL;
          end
        end
        DONE: begin
          busy   <= 1'b0;
          done   <= 1'b1;
          err    <= chk_fail;
          result <= acc;
          state  <= IDLE;
        end
        default: begin
          if (wt != WT_MAX) begin
            wt <= wt + WT_W'(1);
          end else begin
            wt <= '0;
            case (state)
              DBL: begin
                t        <= alu_res;
                state    <= CMP1;
                alu_ctrl <= ALU_SLT;
                alu_in1  <= alu_res;
                alu_in2  <= n_r;
              end
              ADD: begin
                t        <= alu_res;
                state    <= CMP2;
                alu_ctrl <= ALU_SLT;
                alu_in1  <= alu_res;
                alu_in2  <= n_r;
              end
              default: begin
                if ((state == CMP1 || state == CMP2) && !slt_true) begin
                  // t >= n: subtract once to bring it back into range
                  state    <= (state == CMP1) ? SUB1 : SUB2;
                  alu_ctrl <= ALU_SUB;
                  alu_in1  <= t;
                  alu_in2  <= n_r;
                end else if ((state == CMP1 || state == SUB1) && bit_set) begin
                  t        <= red_val;
                  state    <= ADD;
                  alu_ctrl <= ALU_ADD;
                  alu_in1  <= red_val;
                  alu_in2  <= a_r;
                end else begin
                  // bit finished: commit to acc and move on
                  acc      <= red_val;
                  t        <= red_val;
                  alu_ctrl <= ALU_ADD;
                  if (i == '0) begin
                    state   <= DONE;
                    alu_in1 <= '0;
                    alu_in2 <= '0;
                  end else begin
                    i       <= i - IW'(1);
                    state   <= DBL;
                    alu_in1 <= red_val;
                    alu_in2 <= red_val;
                  end
                end
              end
            endcase
          end
        end
      endcase
    end
  end

`ifdef MODMUL_CYCLE_CNT_EN
  // Busy-cycle counter: cleared on start acceptance, saturating, frozen once busy drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt <= '0;
    end else if (state == IDLE && start) begin
      cyc_cnt <= '0;
    end else if (busy && cyc_cnt != 16'hFFFF) begin
      cyc_cnt <= cyc_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_modmul_seq.sv
// Testbench for modmul_seq with a registered ALU model beside the DUT.
module tb_modmul_seq;
  import rsa_pkg::*;

  localparam int ALU_LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0, n = '0;
  logic        busy, done, err;
  logic [15:0] result;
  logic [2:0]  alu_ctrl;
  logic [15:0] alu_in1, alu_in2;
  logic [15:0] alu_res = '0;
  logic        alu_zero = 1'b0;
`ifdef MODMUL_CYCLE_CNT_EN
  logic [15:0] cyc_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  modmul_seq #(.WIDTH(16), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .n(n),
    .busy(busy), .done(done), .err(err), .result(result),
    .alu_ctrl(alu_ctrl), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_res(alu_res), .alu_zero(alu_zero)
`ifdef MODMUL_CYCLE_CNT_EN
    , .cyc_cnt(cyc_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Registered 16-bit ALU: result valid one edge after its inputs.
  always @(posedge clk) begin
    case (alu_ctrl)
      ALU_ADD: alu_res <= alu_in1 + alu_in2;
      ALU_SUB: alu_res <= alu_in1 - alu_in2;
      ALU_AND: alu_res <= alu_in1 & alu_in2;
      ALU_OR:  alu_res <= alu_in1 | alu_in2;
      ALU_SLT: alu_res <= (alu_in1 < alu_in2) ? 16'd1 : 16'd0;
      default: alu_res <= 16'd0;
    endcase
    alu_zero <= (alu_res == 16'd0);
  end

  typedef struct {
    logic [15:0] va, vb, vn;
    logic [15:0] eres;
    logic        eerr;
    int          elat;
  } vec_t;

  vec_t tbl[10];

  function automatic logic is_bad(input logic [15:0] mn);
    return (mn == 16'd0) || (mn >= 16'h8000);
  endfunction

  function automatic logic [15:0] ref_res(input logic [15:0] ma, mb, mn);
    longint p;
    if (is_bad(mn)) return 16'd0;
    p = longint'(ma) * longint'(mb);
    return 16'(p % longint'(mn));
  endfunction

  // Cycles from the start edge to the done pulse: each ALU op costs 1+ALU_LAT
  // cycles, each bit always doubles and compares, a set bit adds and compares,
  // and a value >= n costs one extra subtract; plus one cycle in DONE.
  function automatic int ref_lat(input logic [15:0] ma, mb, mn);
    int op;
    int cyc;
    int acc;
    int tv;
    if (is_bad(mn)) return 1;
    op  = 1 + ALU_LAT;
    cyc = 0;
    acc = 0;
    for (int k = 15; k >= 0; k--) begin
      tv  = 2 * acc;
      cyc = cyc + 2 * op;
      if (tv >= int'(mn)) begin tv = tv - int'(mn); cyc = cyc + op; end
      if (mb[k]) begin
        tv  = tv + int'(ma);
        cyc = cyc + 2 * op;
        if (tv >= int'(mn)) begin tv = tv - int'(mn); cyc = cyc + op; end
      end
      acc = tv;
    end
    return cyc + 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input string nm, input logic [15:0] ta, tb_, tn,
                        input logic [15:0] er, input logic ee, input int el,
                        input bit noise);
    int k;
    bit got;
    bit busy_ok;
    bit alu_ok;
    logic [15:0] rres;
    logic rerr;
    rres = '0;
    rerr = 1'b0;
    @(negedge clk);
    a = ta; b = tb_; n = tn; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    busy_ok = busy;
    alu_ok = 1'b1;
    got = 1'b0;
    k = 0;
    if (ee && (alu_ctrl != ALU_ADD || alu_in1 != 16'd0 || alu_in2 != 16'd0)) alu_ok = 1'b0;
    while (!got && k < 2000) begin
      if (noise && k >= 2 && k < 12) begin
        start = 1'b1; a = 16'($urandom); b = 16'($urandom); n = 16'h0003;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
      if (ee && (alu_ctrl != ALU_ADD || alu_in1 != 16'd0 || alu_in2 != 16'd0)) alu_ok = 1'b0;
      if (done) begin
        got = 1'b1; rres = result; rerr = err;
        if (busy) busy_ok = 1'b0;
      end else if (!busy) begin
        busy_ok = 1'b0;
      end
    end
    start = 1'b0;
    chk({nm, " done_seen"}, 32'(got), 32'd1);
    chk({nm, " result"}, 32'(rres), 32'(er));
    chk({nm, " err"}, 32'(rerr), 32'(ee));
    chk({nm, " latency"}, 32'(k), 32'(el));
    chk({nm, " busy_window"}, 32'(busy_ok), 32'd1);
    if (ee) chk({nm, " alu_quiet"}, 32'(alu_ok), 32'd1);
    @(negedge clk);
    chk({nm, " done_one_cycle"}, 32'(done), 32'd0);
    @(negedge clk);
    chk({nm, " result_held"}, 32'(result), 32'(er));
`ifdef MODMUL_CYCLE_CNT_EN
    chk({nm, " cyc_cnt"}, 32'(cyc_cnt), 32'(el));
`endif
  endtask

  initial begin
    tbl[0] = '{16'd3,     16'd5,      16'd7,      16'd1,    1'b0, 0};
    tbl[1] = '{16'd100,   16'd0,      16'h7FFF,   16'd0,    1'b0, 65};
    tbl[2] = '{16'h7FFE,  16'h7FFE,   16'h7FFF,   16'd1,    1'b0, 0};
    tbl[3] = '{16'd0,     16'h1234,   16'h8001,   16'd0,    1'b1, 1};
    tbl[4] = '{16'd5,     16'd5,      16'd0,      16'd0,    1'b1, 1};
    tbl[5] = '{16'd5,     16'd1,      16'd13,     16'd5,    1'b0, 0};
    tbl[6] = '{16'd0,     16'hFFFF,   16'd1,      16'd0,    1'b0, 0};
    tbl[7] = '{16'd12,    16'd12,     16'h7FFF,   16'h0090, 1'b0, 0};
    tbl[8] = '{16'h4000,  16'd2,      16'h7FFF,   16'd1,    1'b0, 0};
    tbl[9] = '{16'd6,     16'hFFFF,   16'd11,     16'd4,    1'b0, 0};
    for (int j = 0; j < 10; j++)
      if (tbl[j].elat == 0) tbl[j].elat = ref_lat(tbl[j].va, tbl[j].vb, tbl[j].vn);

    // reset state
    repeat (2) @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst result", 32'(result), 32'd0);
    chk("rst alu_ctrl", 32'(alu_ctrl), 32'(ALU_ADD));
    chk("rst alu_in1", 32'(alu_in1), 32'd0);
    chk("rst alu_in2", 32'(alu_in2), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int j = 0; j < 10; j++)
      run_op($sformatf("vec%0d", j), tbl[j].va, tbl[j].vb, tbl[j].vn,
             tbl[j].eres, tbl[j].eerr, tbl[j].elat, 1'b0);

    // start pulses with other operands while busy must be ignored
    run_op("noise", 16'd3, 16'd5, 16'd7, 16'd1, 1'b0, ref_lat(16'd3, 16'd5, 16'd7), 1'b1);

    // reset in the middle of an operation
    @(negedge clk);
    a = 16'd3; b = 16'd5; n = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("midop busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst err", 32'(err), 32'd0);
    chk("midrst result", 32'(result), 32'd0);
    chk("midrst alu_ctrl", 32'(alu_ctrl), 32'(ALU_ADD));
    chk("midrst alu_in", 32'({alu_in1, alu_in2}), 32'd0);
`ifdef MODMUL_CYCLE_CNT_EN
    chk("midrst cyc_cnt", 32'(cyc_cnt), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    run_op("after_rst", 16'd3, 16'd5, 16'd7, 16'd1, 1'b0, ref_lat(16'd3, 16'd5, 16'd7), 1'b0);

    // randomized operands against the reference model
    for (int j = 0; j < 20; j++) begin
      logic [15:0] rn, ra, rb;
      rn = 16'($urandom_range(1, 16'h7FFF));
      ra = 16'($urandom % rn);
      rb = 16'($urandom);
      run_op($sformatf("rnd%0d", j), ra, rb, rn, ref_res(ra, rb, rn), 1'b0,
             ref_lat(ra, rb, rn), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
